// File: rtl/sram_arbiter.sv
// Two-master round-robin arbiter in front of one pipelined Avalon-MM SRAM controller port.
// A tag FIFO remembers which master issued each outstanding read so returns are steered back.
module sram_arbiter #(
    parameter int MAX_RD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] m0_address,
    input  logic [1:0]  m0_byteenable,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [15:0] m0_writedata,
    output logic        m0_waitrequest,
    output logic [15:0] m0_readdata,
    output logic        m0_readdatavalid,
    input  logic [19:0] m1_address,
    input  logic [1:0]  m1_byteenable,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [15:0] m1_writedata,
    output logic        m1_waitrequest,
    output logic [15:0] m1_readdata,
    output logic        m1_readdatavalid,
    output logic [19:0] s_address,
    output logic [1:0]  s_byteenable,
    output logic        s_read,
    output logic        s_write,
    output logic [15:0] s_writedata,
    input  logic [15:0] s_readdata,
    input  logic        s_readdatavalid,
    output logic        err_orphan
);
    localparam int PW = $clog2(MAX_RD);

    logic [19:0]       r_s_address;
    logic [1:0]        r_s_byteenable;
    logic              r_s_read;
    logic              r_s_write;
    logic [15:0]       r_s_writedata;
    logic              r_last_grant;
    logic              r_err_orphan;
    logic [MAX_RD-1:0] r_fifo;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [PW:0]       r_count;

    logic w_req0, w_req1, w_full, w_empty;
    logic w_elig0, w_elig1, w_gnt0, w_gnt1, w_gnt;
    logic w_sel_read, w_sel_write, w_push, w_pop, w_head;

    assign w_req0  = m0_read | m0_write;
    assign w_req1  = m1_read | m1_write;
    // Full uses the registered count only: a pop in this cycle cannot admit a read in the same cycle.
    assign w_full  = (r_count == (PW+1)'(MAX_RD));
    assign w_empty = (r_count == '0);
    assign w_elig0 = m0_read ? ~w_full : m0_write;
    assign w_elig1 = m1_read ? ~w_full : m1_write;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            if (w_elig0 && w_elig1) begin
                if (r_last_grant) w_gnt0 = 1'b1;
                else              w_gnt1 = 1'b1;
            end else if (w_elig0) begin
                w_gnt0 = 1'b1;
            end else if (w_elig1) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign w_gnt       = w_gnt0 | w_gnt1;
    assign w_sel_read  = w_gnt1 ? m1_read  : m0_read;
    assign w_sel_write = w_gnt1 ? m1_write : m0_write;
    assign w_push      = w_gnt & w_sel_read;
    assign w_pop       = s_readdatavalid & ~w_empty;
    assign w_head      = r_fifo[r_rptr];

    assign m0_waitrequest   = w_req0 & ~w_gnt0;
    assign m1_waitrequest   = w_req1 & ~w_gnt1;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = w_pop & ~w_head;
    assign m1_readdatavalid = w_pop &  w_head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s_address    <= '0;
            r_s_byteenable <= '0;
            r_s_read       <= 1'b0;
            r_s_write      <= 1'b0;
            r_s_writedata  <= '0;
            r_last_grant   <= 1'b1;
            r_err_orphan   <= 1'b0;
            r_fifo         <= '0;
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
        end else begin
            // A read+write request issues only the read; the write half is dropped.
            r_s_read  <= w_gnt & w_sel_read;
            r_s_write <= w_gnt & w_sel_write & ~w_sel_read;
            if (w_gnt) begin
                r_s_address    <= w_gnt1 ? m1_address    : m0_address;
                r_s_byteenable <= w_gnt1 ? m1_byteenable : m0_byteenable;
                r_s_writedata  <= w_gnt1 ? m1_writedata  : m0_writedata;
                r_last_grant   <= w_gnt1;
            end
            if (w_push) begin
                r_fifo[r_wptr] <= w_gnt1;
                r_wptr         <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
            if (s_readdatavalid && w_empty) r_err_orphan <= 1'b1;
        end
    end

    assign s_address    = r_s_address;
    assign s_byteenable = r_s_byteenable;
    assign s_read       = r_s_read;
    assign s_write      = r_s_write;
    assign s_writedata  = r_s_writedata;
    assign err_orphan   = r_err_orphan;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_sram_arbiter;
    localparam int MAX_RD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] m0_address, m1_address;
    logic [1:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [15:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [15:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [19:0] s_address;
    logic [1:0]  s_byteenable;
    logic        s_read, s_write;
    logic [15:0] s_writedata;
    logic [15:0] s_readdata;
    logic        s_readdatavalid;
    logic        err_orphan;

    sram_arbiter #(.MAX_RD(MAX_RD)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read),
        .s_write(s_write), .s_writedata(s_writedata), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: outstanding reads as a queue of master IDs, plus expected controller command.
    int          q[$];
    int          last_g;
    logic [19:0] e_addr;
    logic [1:0]  e_be;
    logic [15:0] e_wd;
    logic        e_rd, e_wr, e_orph;
    int          obs_g;
    int          g_hist[$];

    task automatic model_reset();
        q.delete();
        last_g = 1;
        e_addr = '0; e_be = '0; e_wd = '0;
        e_rd = 1'b0; e_wr = 1'b0; e_orph = 1'b0;
    endtask

    // Called just after a rising edge with inputs already driven; checks this cycle and the next edge.
    task automatic step();
        int g;
        bit req0, req1, full, e0, e1, x0, x1;
        #1;
        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;
        full = q.size() >= MAX_RD;
        e0 = m0_read ? !full : m0_write;
        e1 = m1_read ? !full : m1_write;
        g = -1;
        if (e0 && e1) g = (last_g == 1) ? 0 : 1;
        else if (e0)  g = 0;
        else if (e1)  g = 1;
        check("wait0", 32'(m0_waitrequest), 32'(req0 && g != 0));
        check("wait1", 32'(m1_waitrequest), 32'(req1 && g != 1));
        x0 = s_readdatavalid && q.size() > 0 && q[0] == 0;
        x1 = s_readdatavalid && q.size() > 0 && q[0] == 1;
        check("rdv0", 32'(m0_readdatavalid), 32'(x0));
        check("rdv1", 32'(m1_readdatavalid), 32'(x1));
        if (x0) check("rdata0", 32'(m0_readdata), 32'(s_readdata));
        if (x1) check("rdata1", 32'(m1_readdata), 32'(s_readdata));
        obs_g = -1;
        if (req0 && !m0_waitrequest)      obs_g = 0;
        else if (req1 && !m1_waitrequest) obs_g = 1;
        if (s_readdatavalid) begin
            if (q.size() > 0) void'(q.pop_front());
            else              e_orph = 1'b1;
        end
        if (g >= 0) begin
            e_addr = (g == 1) ? m1_address    : m0_address;
            e_be   = (g == 1) ? m1_byteenable : m0_byteenable;
            e_wd   = (g == 1) ? m1_writedata  : m0_writedata;
            e_rd   = (g == 1) ? m1_read : m0_read;
            e_wr   = ((g == 1) ? m1_write : m0_write) && !e_rd;
            if (e_rd) q.push_back(g);
            last_g = g;
        end else begin
            e_rd = 1'b0;
            e_wr = 1'b0;
        end
        @(posedge clk);
        #1;
        check("s_read", 32'(s_read), 32'(e_rd));
        check("s_write", 32'(s_write), 32'(e_wr));
        check("s_address", 32'(s_address), 32'(e_addr));
        check("s_byteenable", 32'(s_byteenable), 32'(e_be));
        check("s_writedata", 32'(s_writedata), 32'(e_wd));
        check("err_orphan", 32'(err_orphan), 32'(e_orph));
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_s_read", 32'(s_read), 32'd0);
        check("rst_s_write", 32'(s_write), 32'd0);
        check("rst_s_address", 32'(s_address), 32'd0);
        check("rst_wait0", 32'(m0_waitrequest), 32'(m0_read | m0_write));
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_err_orphan", 32'(err_orphan), 32'd0);
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * MAX_RD && q.size() > 0; k++) begin
            s_readdatavalid = 1'b1;
            s_readdata = 16'($urandom);
            step();
        end
        s_readdatavalid = 1'b0;
        check("drained", 32'(q.size()), 32'd0);
    endtask

    bit          pend0, pend1;
    int          r;
    int          zero_i;

    initial begin
        reset = 1'b1;
        m0_address = '0; m0_byteenable = '0; m0_read = 1'b1; m0_write = 1'b0; m0_writedata = '0;
        m1_address = '0; m1_byteenable = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0;
        s_readdata = '0; s_readdatavalid = 1'b0;
        model_reset();
        #2;
        check("init_s_read", 32'(s_read), 32'd0);
        check("init_s_address", 32'(s_address), 32'd0);
        check("init_err", 32'(err_orphan), 32'd0);
        check("init_wait0", 32'(m0_waitrequest), 32'd1);
        check("init_wait1", 32'(m1_waitrequest), 32'd0);
        check("init_rdv0", 32'(m0_readdatavalid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m0_read = 1'b0;

        // Single write
        m0_write = 1'b1; m0_address = 20'h12345; m0_writedata = 16'hBEEF; m0_byteenable = 2'b01;
        step();
        m0_write = 1'b0;
        step();

        // Contention: both masters read continuously, returns keep the FIFO from filling
        m0_read = 1'b1; m0_address = 20'h00100;
        m1_read = 1'b1; m1_address = 20'h00200;
        for (int i = 0; i < 6; i++) begin
            s_readdatavalid = (q.size() > 0);
            s_readdata = 16'($urandom);
            step();
            g_hist.push_back(obs_g);
        end
        m0_read = 1'b0; m1_read = 1'b0;
        for (int i = 1; i < 6; i++) check("alternate", 32'(g_hist[i]), 32'(1 - g_hist[i-1]));
        drain();

        // Return routing
        m1_read = 1'b1; m1_address = 20'h00010;
        step();
        m1_read = 1'b0; m0_read = 1'b1; m0_address = 20'h00020;
        step();
        m0_read = 1'b0;
        step();
        s_readdatavalid = 1'b1; s_readdata = 16'hAAAA;
        #1;
        check("route_m1", 32'(m1_readdatavalid), 32'd1);
        step();
        s_readdata = 16'h5555;
        #1;
        check("route_m0", 32'(m0_readdatavalid), 32'd1);
        check("route_m0_data", 32'(m0_readdata), 32'h5555);
        step();
        s_readdatavalid = 1'b0;

        // Full FIFO blocks reads but not writes
        m0_read = 1'b1;
        for (int i = 0; i < MAX_RD; i++) begin
            m0_address = 20'(i + 20'h300);
            step();
        end
        m0_address = 20'h00444;
        m1_write = 1'b1; m1_address = 20'h00555; m1_writedata = 16'h1234; m1_byteenable = 2'b11;
        step();
        check("full_block", 32'(obs_g), 32'd1);
        m1_write = 1'b0;
        s_readdatavalid = 1'b1; s_readdata = 16'h7777;
        step();
        check("full_same_cycle_pop", 32'(obs_g), 32'hFFFF_FFFF);
        s_readdatavalid = 1'b0;
        step();
        check("full_unblocked", 32'(obs_g), 32'd0);
        m0_read = 1'b0;
        drain();

        // Orphan return
        s_readdatavalid = 1'b1;
        step();
        s_readdatavalid = 1'b0;
        check("orphan_set", 32'(err_orphan), 32'd1);
        step();
        step();
        check("orphan_sticky", 32'(err_orphan), 32'd1);

        // Random traffic with one mid-burst reset
        pend0 = 1'b0; pend1 = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (c == 400) do_reset();
            if (!pend0) begin
                m0_read = 1'b0; m0_write = 1'b0;
                if ($urandom_range(0, 1) == 1) begin
                    r = $urandom_range(0, 9);
                    m0_read = (r < 5) || (r == 9);
                    m0_write = (r >= 5);
                    m0_address = 20'($urandom); m0_byteenable = 2'($urandom);
                    m0_writedata = 16'($urandom);
                    pend0 = 1'b1;
                end
            end
            if (!pend1) begin
                m1_read = 1'b0; m1_write = 1'b0;
                if ($urandom_range(0, 1) == 1) begin
                    r = $urandom_range(0, 9);
                    m1_read = (r < 5) || (r == 9);
                    m1_write = (r >= 5);
                    m1_address = 20'($urandom); m1_byteenable = 2'($urandom);
                    m1_writedata = 16'($urandom);
                    pend1 = 1'b1;
                end
            end
            s_readdatavalid = (q.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) < 2);
            s_readdata = 16'($urandom);
            step();
            if (obs_g == 0) pend0 = 1'b0;
            if (obs_g == 1) pend1 = 1'b0;
        end
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        drain();
        zero_i = 0;
        check("final_inflight", 32'(q.size()), 32'(zero_i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
